// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: stall bit positions,
// exception codes and FSM state encodings.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_IF_PAT = 6'b000011;
  localparam logic [5:0] STALL_ID_PAT = 6'b000111;
  localparam logic [5:0] STALL_EX_PAT = 6'b001111;

  localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_BREAK        = 32'h0000_0009;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MADD2    = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_exc_vec_sel.sv
// Maps the exception code from MEM to the redirect PC.
module pipe_ctrl_exc_vec_sel
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] new_pc_o
);

  always_comb begin
    new_pc_o = 32'h0;
    case (excepttype_i)
      32'h0:            new_pc_o = 32'h0;
      EXC_INTERRUPT:    new_pc_o = INT_VECTOR;
      EXC_SYSCALL,
      EXC_BREAK,
      EXC_INST_INVALID,
      EXC_OVERFLOW,
      EXC_TRAP:         new_pc_o = EXC_VECTOR;
      EXC_ERET:         new_pc_o = cp0_epc_i;
      default:          new_pc_o = EXC_VECTOR;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests, sequences multi-cycle EX ops,
// and issues flush/redirect on exceptions.
//
// state       | meaning
// ST_IDLE     | no multi-cycle op in flight
// ST_MADD2    | second cycle of multiply-accumulate, no stall
// ST_DIV_WAIT | divider running, EX held until div_ready_i
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        ex_multi_i,
  input  logic        ex_div_i,
  input  logic        div_ready_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [1:0]  cnt_o,
  output logic        div_start_o,
  output logic        div_annul_o
);

  state_e      state_q, state_d;
  logic        exc;
  logic        ex_busy;
  logic [5:0]  stall_c;
  logic [1:0]  cnt_c;
  logic        div_start_c;
  logic        div_annul_c;
  logic [31:0] new_pc_c;

  assign exc = (excepttype_i != 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ex_busy     = 1'b0;
    cnt_c       = 2'd0;
    div_start_c = 1'b0;
    div_annul_c = 1'b0;
    stall_c     = STALL_NONE;

    case (state_q)
      ST_IDLE: begin
        ex_busy     = ex_multi_i | ex_div_i;
        div_start_c = ex_div_i & ~exc;
        if (ex_multi_i)    state_d = ST_MADD2;
        else if (ex_div_i) state_d = ST_DIV_WAIT;
      end
      ST_MADD2: begin
        cnt_c   = 2'd1;
        state_d = ST_IDLE;
      end
      ST_DIV_WAIT: begin
        ex_busy     = ~div_ready_i;
        div_start_c = ~div_ready_i & ~exc;
        div_annul_c = exc;
        if (div_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (exc) state_d = ST_IDLE;

    if (exc)                   stall_c = STALL_NONE;
    else if (ex_busy)          stall_c = STALL_EX_PAT;
    else if (stallreq_from_id) stall_c = STALL_ID_PAT;
    else if (stallreq_from_if) stall_c = STALL_IF_PAT;
  end

  pipe_ctrl_exc_vec_sel #(
    .EXC_VECTOR (EXC_VECTOR),
    .INT_VECTOR (INT_VECTOR)
  ) u_exc_vec_sel (
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .new_pc_o     (new_pc_c)
  );

  // Reset forces outputs low without waiting for an edge, so a divide in
  // flight drops its run request as soon as reset is asserted.
  assign stall_o     = rst ? stall_c : STALL_NONE;
  assign flush_o     = rst & exc;
  assign new_pc_o    = rst ? new_pc_c : 32'h0;
  assign cnt_o       = rst ? cnt_c : 2'd0;
  assign div_start_o = rst & div_start_c;
  assign div_annul_o = rst & div_annul_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id;
  logic        ex_multi_i, ex_div_i, div_ready_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [1:0]  cnt_o;
  logic        div_start_o, div_annul_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic        ds;
    logic        da;
  } exp_t;

  exp_t exp_q[$];

  // Model state: which multi-cycle op (if any) is outstanding.
  bit m_madd_second = 0;
  bit m_div_wait    = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .ex_multi_i       (ex_multi_i),
    .ex_div_i         (ex_div_i),
    .div_ready_i      (div_ready_i),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall_o          (stall_o),
    .flush_o          (flush_o),
    .new_pc_o         (new_pc_o),
    .cnt_o            (cnt_o),
    .div_start_o      (div_start_o),
    .div_annul_o      (div_annul_o)
  );

  function automatic logic [31:0] ref_vec(input logic [31:0] code, input logic [31:0] epc);
    if (code == 32'h0)  return 32'h0;
    if (code == 32'h1)  return 32'h20;
    if (code == 32'he)  return epc;
    return 32'h40;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit exc, idle, busy;
    e.stall = 6'b0; e.flush = 0; e.pc = 32'h0; e.cnt = 2'd0; e.ds = 0; e.da = 0;
    if (rst) begin
      exc  = (excepttype_i != 0);
      idle = !m_madd_second && !m_div_wait;
      busy = (idle && (ex_multi_i || ex_div_i)) || (m_div_wait && !div_ready_i);
      e.flush = exc;
      e.pc    = ref_vec(excepttype_i, cp0_epc_i);
      e.cnt   = m_madd_second ? 2'd1 : 2'd0;
      e.ds    = !exc && ((idle && ex_div_i) || (m_div_wait && !div_ready_i));
      e.da    = m_div_wait && exc;
      if (exc)                   e.stall = 6'b000000;
      else if (busy)             e.stall = 6'b001111;
      else if (stallreq_from_id) e.stall = 6'b000111;
      else if (stallreq_from_if) e.stall = 6'b000011;
    end
    return e;
  endfunction

  function automatic void model_advance(input bit r);
    bit idle;
    idle = !m_madd_second && !m_div_wait;
    if (!r || excepttype_i != 0) begin
      m_madd_second = 0; m_div_wait = 0;
    end else if (m_madd_second) begin
      m_madd_second = 0;
    end else if (m_div_wait) begin
      if (div_ready_i) m_div_wait = 0;
    end else if (idle) begin
      if (ex_multi_i)    m_madd_second = 1;
      else if (ex_div_i) m_div_wait = 1;
    end
  endfunction

  task automatic step(input bit r, input bit sif, input bit sid, input bit mul,
                      input bit dv, input bit rdy, input logic [31:0] ex,
                      input logic [31:0] epc);
    rst = r; stallreq_from_if = sif; stallreq_from_id = sid;
    ex_multi_i = mul; ex_div_i = dv; div_ready_i = rdy;
    excepttype_i = ex; cp0_epc_i = epc;
    exp_q.push_back(model_expect());
    @(posedge clk);
    model_advance(r);
    #1;
  endtask

  task automatic idle_step();
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",     {26'h0, stall_o},     {26'h0, e.stall});
      chk("flush",     {31'h0, flush_o},     {31'h0, e.flush});
      chk("new_pc",    new_pc_o,             e.pc);
      chk("cnt",       {30'h0, cnt_o},       {30'h0, e.cnt});
      chk("div_start", {31'h0, div_start_o}, {31'h0, e.ds});
      chk("div_annul", {31'h0, div_annul_o}, {31'h0, e.da});
    end
  end

  logic [31:0] codes [8];

  initial begin
    codes[0] = 32'h1; codes[1] = 32'h8; codes[2] = 32'h9; codes[3] = 32'ha;
    codes[4] = 32'hc; codes[5] = 32'hd; codes[6] = 32'he; codes[7] = 32'h77;

    rst = 0; stallreq_from_if = 0; stallreq_from_id = 0; ex_multi_i = 0;
    ex_div_i = 0; div_ready_i = 0; excepttype_i = 0; cp0_epc_i = 0;
    @(posedge clk); #1;

    // Reset held with random inputs: everything quiet.
    for (int i = 0; i < 4; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 15), $urandom);
    idle_step(); idle_step();

    // Multiply-accumulate: two cycles.
    step(1, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    idle_step();

    // Divide with ready on cycle 34.
    for (int c = 0; c < 34; c++) step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    idle_step();

    // Exception mid-divide, then idle the next cycle.
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h8, 32'h0);
    idle_step();

    // Eret and interrupt redirects.
    step(1, 0, 0, 0, 0, 0, 32'he, 32'h1234);
    step(1, 0, 0, 0, 0, 0, 32'h1, 32'h1234);

    // IF+ID stall together, then with a divide arriving.
    step(1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
    step(1, 1, 1, 0, 1, 0, 32'h0, 32'h0);
    step(1, 1, 1, 0, 0, 1, 32'h0, 32'h0);

    // Illegal decode: multi and div together, multi wins.
    step(1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    idle_step();

    // Async reset mid-divide with ex_div_i still high.
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    idle_step(); idle_step();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] ex;
      ex = ($urandom_range(0, 15) == 0) ? codes[$urandom_range(0, 7)] : 32'h0;
      step(1, 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), ex, $urandom);
    end
    idle_step();

    @(negedge clk); @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
